particle_unloader: RTL and testbench
====================================

# particle_unloader

Streams particle records from the simulator's particle memory to an external consumer. It is the read-back path, the mirror of the `data_in` / `data_in_ready` / `elem_write` load path. On `start` it walks addresses 0..N_PARTICLES-1 through a fixed-latency BRAM read port and presents each 256-bit record on a valid/ready output stream. A small credit-controlled buffer absorbs read latency under backpressure, so no record is dropped or duplicated.

## Interface
Parameters:
- `N_PARTICLES`, 300, number of records to unload per run
- `DATA_W`, 256, record width in bits
- `ADDR_W`, 9, read address width; must satisfy 2^ADDR_W >= N_PARTICLES
- `RD_LAT`, 2, BRAM read latency in cycles from `rd_en` to `rd_data`, range 1..4

Ports:
- `fast_clk`, in, 1, the single clock; all logic is on its rising edge
- `reset`, in, 1, asynchronous, active-low reset
- `start`, in, 1, one-cycle pulse that begins an unload; ignored while `busy`=1
- `busy`, out, 1, high from the cycle after an accepted `start` until `done`
- `done`, out, 1, one-cycle pulse after the last record handshakes
- `rd_en`, out, 1, BRAM read enable
- `rd_addr`, out, ADDR_W, BRAM read address
- `rd_data`, in, DATA_W, BRAM read data, valid RD_LAT cycles after `rd_en`
- `data_out`, out, DATA_W, output record
- `data_out_valid`, out, 1, `data_out` holds a record
- `data_out_ready`, in, 1, consumer accepts the record
- `elem_count`, out, ADDR_W+1, number of records handshaked in the current run

## Operation
- FSM states: IDLE, FETCH, DRAIN, DONE.
- IDLE → FETCH on `start`. On entry: address counter, in-flight counter and `elem_count` are cleared.
- FETCH issues `rd_en`=1 with `rd_addr`=address counter only while (in-flight + buffer occupancy) < DEPTH, where DEPTH = RD_LAT+1. The address increments on each issue.
- FETCH → DRAIN in the cycle the read of address N_PARTICLES-1 is issued.
- DRAIN → DONE when the last record handshakes, i.e. `elem_count` reaches N_PARTICLES.
- DONE asserts `done` for one cycle, then returns to IDLE.
- Returned `rd_data` is pushed into the buffer exactly RD_LAT cycles after its issue. A delay-line shift register of `rd_en` tags the returning data.
- The output is the head of the buffer. `data_out_valid` = buffer not empty.
- A handshake is `data_out_valid` & `data_out_ready`. It pops the buffer and increments `elem_count`.
- Records leave strictly in address order. There are no gaps or repeats.
- The credit rule guarantees the buffer never overflows. A push while the buffer is full is an error condition and must never occur.
- `start` while `busy`: ignored, with no restart and no state change.
- `data_out_ready` held low indefinitely: issue stalls with at most DEPTH records outstanding, and `data_out` stays stable while valid.

## Timing
- Reset values: `busy`=0, `done`=0, `rd_en`=0, `rd_addr`=0, `data_out_valid`=0, `data_out`=0, `elem_count`=0; FSM in IDLE; buffer empty.
- Reset asserted mid-run aborts immediately. No `done` pulse is produced, and in-flight read data arriving after reset release is discarded.
- `start` at cycle 0 gives the first `rd_en` at cycle 1 and the first `data_out_valid` at cycle 1+RD_LAT+1, registered through the buffer.
- With `data_out_ready` held at 1, throughput is one record per cycle. `done` occurs at cycle N_PARTICLES+RD_LAT+2 after `start`.
- A simultaneous push and pop when the buffer is full is legal and leaves occupancy unchanged. With the buffer empty, a push becomes valid the next cycle; there is no combinational bypass.
- `data_out`, `data_out_valid`, `busy` and `done` are all registered outputs.

## Structure
- Shared package `md_pkg`: `PARTICLE_W` = 256 and the particle record typedef shared with the load path. `N_PARTICLES` defaults come from here.
- Sub-module `particle_skid_fifo`: a synchronous FIFO with parameters DEPTH and DATA_W, registered head, ports push/pop/full/empty/count, and the same async active-low reset.
- Top level contains the FSM, address and credit counters, and the RD_LAT valid delay line.

## Test plan
- Basic run with RD_LAT=2, N_PARTICLES=300, BRAM preloaded with record i = {i repeated in each 32-bit word}, ready held at 1 → 300 records in order 0..299, one per cycle, `done` exactly once at cycle 304 after `start`, and `elem_count`=300.
- Backpressure with ready toggled in a random 30% duty pattern → identical ordered sequence, no drops or repeats, buffer occupancy never exceeds 3, and `data_out` stable while valid and not ready.
- Ready held at 0 for 50 cycles after `start` → exactly 3 reads issued, then `rd_en` stays 0. After release, all 300 records arrive.
- `start` pulsed again at records 10 and 150 → ignored; a single run of 300 records completes and `done` pulses once.
- Reset asserted after 120 records, then released and `start` given → outputs at reset values during reset, and the new run delivers records 0..299 with no stale record 120 or later leaking.
- RD_LAT=1 and RD_LAT=4 regression with N_PARTICLES=1 → a single record 0, and `done` at cycle RD_LAT+3.

Source files
------------

// File: rtl/md_pkg.sv
// Shared particle-simulator definitions: record width, default particle count
// and the unloader FSM state codes.
package md_pkg;

  localparam int PARTICLE_W      = 256;
  localparam int DEF_N_PARTICLES = 300;

  typedef logic [PARTICLE_W-1:0] particle_t;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

endpackage

// File: rtl/particle_unloader_if.sv
// BRAM read port plus the valid/ready output stream of the particle unloader.
interface particle_unloader_if
  import md_pkg::*;
#(
  parameter int DATA_W = PARTICLE_W,
  parameter int ADDR_W = 9
);

  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rd_data;
  logic [DATA_W-1:0] data_out;
  logic              data_out_valid;
  logic              data_out_ready;

  modport master (
    output rd_en, rd_addr, data_out, data_out_valid,
    input  rd_data, data_out_ready
  );

  modport slave (
    input  rd_en, rd_addr, data_out, data_out_valid,
    output rd_data, data_out_ready
  );

endinterface

// File: rtl/particle_skid_fifo.sv
// Small synchronous FIFO whose head entry is held in a register, so the output
// never depends combinationally on the push side.
module particle_skid_fifo #(
  parameter  int DEPTH  = 3,
  parameter  int DATA_W = 256,
  localparam int PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              pop,
  output logic [DATA_W-1:0] head,
  output logic              full,
  output logic              empty,
  output logic [CNT_W-1:0]  count
);

  logic [DATA_W-1:0] mem_r [DEPTH];
  logic [DATA_W-1:0] head_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_nxt_s;
  logic [CNT_W-1:0]  count_r;
  logic              do_push_s;
  logic              do_pop_s;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    if (p == PTR_W'(DEPTH - 1)) begin
      return {PTR_W{1'b0}};
    end else begin
      return p + PTR_W'(1);
    end
  endfunction

  assign do_pop_s  = pop && (count_r != CNT_W'(0));
  assign do_push_s = push && ((count_r != CNT_W'(DEPTH)) || do_pop_s);

  // Read pointer after this cycle's pop, used to preload the head register
  always_comb begin
    rd_ptr_nxt_s = rd_ptr_r;
    if (do_pop_s) begin
      rd_ptr_nxt_s = ptr_inc(rd_ptr_r);
    end else begin
      rd_ptr_nxt_s = rd_ptr_r;
    end
  end

  // Storage array write port
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data;
    end
  end

  // Pointers, occupancy and head register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_r <= {PTR_W{1'b0}};
      wr_ptr_r <= {PTR_W{1'b0}};
      count_r  <= {CNT_W{1'b0}};
      head_r   <= {DATA_W{1'b0}};
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= ptr_inc(wr_ptr_r);
      end
      rd_ptr_r <= rd_ptr_nxt_s;
      count_r  <= count_r + CNT_W'(do_push_s) - CNT_W'(do_pop_s);
      // The incoming word becomes the head when nothing older survives this cycle
      if (do_push_s && ((count_r == CNT_W'(0)) || (do_pop_s && (count_r == CNT_W'(1))))) begin
        head_r <= push_data;
      end else if ((count_r > CNT_W'(1)) || ((count_r == CNT_W'(1)) && !do_pop_s)) begin
        head_r <= mem_r[rd_ptr_nxt_s];
      end else begin
        head_r <= head_r;
      end
    end
  end

  assign head  = head_r;
  assign full  = (count_r == CNT_W'(DEPTH));
  assign empty = (count_r == CNT_W'(0));
  assign count = count_r;

endmodule

// File: rtl/particle_unloader.sv
// Walks particle memory 0..N_PARTICLES-1 through a fixed-latency BRAM port and
// streams the records out in order, with credits sized to the read latency.
module particle_unloader
  import md_pkg::*;
#(
  parameter int N_PARTICLES = DEF_N_PARTICLES,
  parameter int DATA_W      = PARTICLE_W,
  parameter int ADDR_W      = 9,
  parameter int RD_LAT      = 2
) (
  input  logic              fast_clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W:0]   elem_count,
  particle_unloader_if.master bus
);

  localparam int DEPTH = RD_LAT + 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [1:0]        state_r;
  logic [1:0]        state_nxt_s;
  logic [ADDR_W-1:0] addr_r;
  logic [CNT_W-1:0]  in_flight_r;
  logic [RD_LAT-1:0] tag_r;
  logic [ADDR_W:0]   elem_count_r;
  logic              busy_r;
  logic              done_r;

  logic              issue_s;
  logic              push_s;
  logic              pop_s;
  logic              credit_s;
  logic              last_issue_s;
  logic              last_pop_s;
  logic [CNT_W:0]    credit_sum_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic [DATA_W-1:0] fifo_head_s;

  assign push_s = tag_r[RD_LAT-1];
  assign pop_s  = !fifo_empty_s && bus.data_out_ready;

  // A slot freed by this cycle's pop may be re-issued at once, keeping one record per cycle
  assign credit_sum_s = {1'b0, in_flight_r} + {1'b0, fifo_count_s} - (CNT_W + 1)'(pop_s);
  assign credit_s     = credit_sum_s < (CNT_W + 1)'(DEPTH);
  assign issue_s      = (state_r == ST_FETCH) && credit_s && (!fifo_full_s || pop_s);
  assign last_issue_s = issue_s && (addr_r == ADDR_W'(N_PARTICLES - 1));
  assign last_pop_s   = pop_s && (elem_count_r == (ADDR_W + 1)'(N_PARTICLES - 1));

  // Next-state logic of the unload sequencer
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) state_nxt_s = ST_FETCH;
        else       state_nxt_s = ST_IDLE;
      end
      ST_FETCH: begin
        if (last_issue_s) state_nxt_s = ST_DRAIN;
        else              state_nxt_s = ST_FETCH;
      end
      ST_DRAIN: begin
        if (last_pop_s) state_nxt_s = ST_DONE;
        else            state_nxt_s = ST_DRAIN;
      end
      ST_DONE: begin
        state_nxt_s = ST_IDLE;
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // State, address/credit counters, return-tag delay line and status flags
  always_ff @(posedge fast_clk or negedge reset) begin
    if (!reset) begin
      state_r      <= ST_IDLE;
      addr_r       <= {ADDR_W{1'b0}};
      in_flight_r  <= {CNT_W{1'b0}};
      tag_r        <= {RD_LAT{1'b0}};
      elem_count_r <= {(ADDR_W + 1){1'b0}};
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      tag_r   <= (tag_r << 1'b1) | RD_LAT'(issue_s);
      busy_r  <= (state_nxt_s != ST_IDLE);
      done_r  <= (state_nxt_s == ST_DONE);
      if ((state_r == ST_IDLE) && start) begin
        addr_r       <= {ADDR_W{1'b0}};
        in_flight_r  <= {CNT_W{1'b0}};
        elem_count_r <= {(ADDR_W + 1){1'b0}};
      end else begin
        if (issue_s) begin
          addr_r <= addr_r + ADDR_W'(1);
        end
        in_flight_r <= in_flight_r + CNT_W'(issue_s) - CNT_W'(push_s);
        if (pop_s) begin
          elem_count_r <= elem_count_r + (ADDR_W + 1)'(1);
        end
      end
    end
  end

  particle_skid_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk       (fast_clk),
    .rst_n     (reset),
    .push      (push_s),
    .push_data (bus.rd_data),
    .pop       (pop_s),
    .head      (fifo_head_s),
    .full      (fifo_full_s),
    .empty     (fifo_empty_s),
    .count     (fifo_count_s)
  );

  assign bus.rd_en          = issue_s;
  assign bus.rd_addr        = addr_r;
  assign bus.data_out       = fifo_head_s;
  assign bus.data_out_valid = !fifo_empty_s;
  assign busy               = busy_r;
  assign done               = done_r;
  assign elem_count         = elem_count_r;

endmodule

// File: tb/tb_particle_unloader.sv
// Self-checking bench for particle_unloader: ordered-stream scoreboard, table of
// ready patterns, reset abort and short-latency single-record instances.
module tb_particle_unloader;
  import md_pkg::*;

  localparam int N   = 300;
  localparam int LAT = 2;
  localparam int AW  = 9;
  localparam int DW  = 256;

  typedef struct {
    int pct;       // percent of cycles with ready high
    int hold;      // cycles of ready low right after start
    int r0;        // record index at which start is re-pulsed (-1 = none)
    int r1;
    int exp_recs;
    int exp_done;  // expected done cycle after start (0 = not checked)
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start, busy, done, ready;
  logic [AW:0]   elem_count;
  logic          start_s, ready_s;
  logic          busy1, done1, busy4, done4;
  logic [1:0]    ec1, ec4;

  particle_unloader_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();
  particle_unloader_if #(.DATA_W(DW), .ADDR_W(1))  bus1 ();
  particle_unloader_if #(.DATA_W(DW), .ADDR_W(1))  bus4 ();

  particle_unloader #(.N_PARTICLES(N), .DATA_W(DW), .ADDR_W(AW), .RD_LAT(LAT)) dut (
    .fast_clk(clk), .reset(rst_n), .start(start), .busy(busy), .done(done),
    .elem_count(elem_count), .bus(bus));
  particle_unloader #(.N_PARTICLES(1), .DATA_W(DW), .ADDR_W(1), .RD_LAT(1)) dut_l1 (
    .fast_clk(clk), .reset(rst_n), .start(start_s), .busy(busy1), .done(done1),
    .elem_count(ec1), .bus(bus1));
  particle_unloader #(.N_PARTICLES(1), .DATA_W(DW), .ADDR_W(1), .RD_LAT(4)) dut_l4 (
    .fast_clk(clk), .reset(rst_n), .start(start_s), .busy(busy4), .done(done4),
    .elem_count(ec4), .bus(bus4));

  function automatic logic [DW-1:0] rec(input int i);
    return {8{32'(i)}};
  endfunction

  function automatic logic [DW-1:0] srec(input int i);
    return {8{32'hA5C3_0000 | 32'(i)}};
  endfunction

  // BRAM models: the record appears RD_LAT cycles after rd_en, junk otherwise
  logic [DW-1:0] pipe [LAT];
  logic [DW-1:0] pipe1;
  logic [DW-1:0] pipe4 [4];
  always @(posedge clk) begin
    pipe[0] <= bus.rd_en ? rec(int'(bus.rd_addr)) : {DW{1'b1}};
    for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    pipe1 <= bus1.rd_en ? srec(int'(bus1.rd_addr)) : {DW{1'b1}};
    pipe4[0] <= bus4.rd_en ? srec(int'(bus4.rd_addr)) : {DW{1'b1}};
    for (int i = 1; i < 4; i++) pipe4[i] <= pipe4[i-1];
  end
  assign bus.rd_data         = pipe[LAT-1];
  assign bus1.rd_data        = pipe1;
  assign bus4.rd_data        = pipe4[3];
  assign bus.data_out_ready  = ready;
  assign bus1.data_out_ready = ready_s;
  assign bus4.data_out_ready = ready_s;

  int total = 0;
  int bad = 0;
  int cyc, exp_idx, issued, done_cnt, done_cyc;
  bit mon_en, chk_tput, last_stall;
  logic [DW-1:0] last_data;
  vec_t vecs [5];

  task automatic chk(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic check_reset_outputs();
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_rd_en", bus.rd_en, 0);
    chk("rst_rd_addr", bus.rd_addr, 0);
    chk("rst_valid", bus.data_out_valid, 0);
    chk("rst_data_out", bus.data_out, 0);
    chk("rst_elem_count", elem_count, 0);
    chk("rst_small_valid", {bus1.data_out_valid, bus4.data_out_valid}, 0);
  endtask

  task automatic run_one(input vec_t v);
    bit r0_hit = 0;
    bit r1_hit = 0;
    int budget = 0;
    exp_idx = 0; issued = 0; done_cnt = 0; done_cyc = -1; last_stall = 0;
    chk_tput = (v.pct == 100) && (v.hold == 0);
    @(posedge clk); #2;
    start = 1'b1; ready = (v.hold == 0); cyc = 0; mon_en = 1'b1;
    @(posedge clk); #2;
    start = 1'b0;
    chk("busy_after_start", busy, 1);
    while (done_cnt == 0 && budget < 6000) begin
      if (v.hold > 0 && cyc == v.hold) begin
        chk("hold_reads_issued", issued, 3);
        chk("hold_rd_en_low", bus.rd_en, 0);
      end
      ready = (cyc < v.hold) ? 1'b0 : ($urandom_range(0, 99) < v.pct);
      start = 1'b0;
      if (!r0_hit && v.r0 >= 0 && exp_idx >= v.r0) begin
        start = 1'b1; r0_hit = 1;
      end else if (!r1_hit && v.r1 >= 0 && exp_idx >= v.r1) begin
        start = 1'b1; r1_hit = 1;
      end
      @(posedge clk); #2;
      budget++;
    end
    start = 1'b0;
    chk("run_reaches_done", done_cnt > 0, 1);
    repeat (4) @(posedge clk);
    #2;
    chk("records", exp_idx, v.exp_recs);
    chk("done_pulses", done_cnt, 1);
    if (v.exp_done > 0) chk("done_cycle", done_cyc, v.exp_done);
    chk("busy_after_done", busy, 0);
    chk("elem_count_final", elem_count, v.exp_recs);
    chk("valid_after_done", bus.data_out_valid, 0);
    mon_en = 1'b0;
  endtask

  initial begin
    vecs[0] = '{100, 0, -1, -1, N, N + LAT + 2};
    vecs[1] = '{30, 0, -1, -1, N, 0};
    vecs[2] = '{100, 50, -1, -1, N, 0};
    vecs[3] = '{100, 0, 10, 150, N, N + LAT + 2};
    vecs[4] = '{70, 0, -1, -1, N, 0};
    mon_en = 1'b0; start = 1'b0; ready = 1'b0; start_s = 1'b0; ready_s = 1'b0;
    cyc = 0; exp_idx = 0; issued = 0; done_cnt = 0; done_cyc = -1;
    chk_tput = 1'b0; last_stall = 1'b0; last_data = '0;

    // Scoreboard: records must leave in address order with bounded outstanding reads
    fork
      forever begin
        @(negedge clk);
        if (mon_en) begin
          if (bus.rd_en) issued++;
          if (last_stall) begin
            chk("stall_data_stable", bus.data_out, last_data);
            chk("stall_valid_held", bus.data_out_valid, 1);
          end
          if (bus.data_out_valid && bus.data_out_ready) begin
            chk("order", bus.data_out, rec(exp_idx));
            if (chk_tput) chk("throughput_cycle", cyc, exp_idx + 4);
            exp_idx++;
          end
          last_stall = bus.data_out_valid && !bus.data_out_ready;
          last_data  = bus.data_out;
          chk("outstanding_le_depth", (issued - exp_idx) <= 3, 1);
          if (done) begin
            done_cnt++;
            done_cyc = cyc;
            chk("elem_count_at_done", elem_count, N);
          end
          cyc++;
        end
      end
    join_none

    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #11;
    check_reset_outputs();
    @(posedge clk); #2;
    rst_n = 1'b1;

    for (int k = 0; k < 5; k++) run_one(vecs[k]);

    // Abort mid-run with a reset shorter than the read latency
    begin
      int budget = 0;
      exp_idx = 0; issued = 0; done_cnt = 0; last_stall = 0; chk_tput = 0;
      @(posedge clk); #2;
      start = 1'b1; ready = 1'b1; cyc = 0; mon_en = 1'b1;
      @(posedge clk); #2;
      start = 1'b0;
      while (exp_idx < 120 && budget < 2000) begin
        ready = ($urandom_range(0, 99) < 50);
        @(posedge clk); #2;
        budget++;
      end
      chk("pre_reset_progress", exp_idx >= 120, 1);
      mon_en = 1'b0;
      rst_n = 1'b0;
      #1;
      check_reset_outputs();
      rst_n = 1'b1;
      ready = 1'b1;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        chk("post_reset_no_stale", bus.data_out_valid, 0);
        chk("post_reset_idle", busy, 0);
      end
      run_one(vecs[0]);
    end

    // Single-record runs at read latency 1 and 4
    begin
      int hs1 = 0, hs4 = 0, d1 = 0, d4 = 0;
      @(posedge clk); #2;
      start_s = 1'b1; ready_s = 1'b1;
      for (int c = 0; c < 14; c++) begin
        @(negedge clk);
        if (bus1.data_out_valid && ready_s) begin
          hs1++;
          chk("lat1_data", bus1.data_out, srec(0));
          chk("lat1_valid_cycle", c, 3);
        end
        if (bus4.data_out_valid && ready_s) begin
          hs4++;
          chk("lat4_data", bus4.data_out, srec(0));
          chk("lat4_valid_cycle", c, 6);
        end
        if (done1) begin d1++; chk("lat1_done_cycle", c, 4); end
        if (done4) begin d4++; chk("lat4_done_cycle", c, 7); end
        @(posedge clk); #2;
        start_s = 1'b0;
      end
      chk("lat1_records", hs1, 1);
      chk("lat4_records", hs4, 1);
      chk("lat1_done_pulses", d1, 1);
      chk("lat4_done_pulses", d4, 1);
      chk("lat1_elem_count", ec1, 1);
      chk("lat4_elem_count", ec4, 1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
